// File: rtl/seg_display_scanner.sv
// Time-multiplexed scanner for a common-anode multi-digit 7-segment display.
// Tear-free value updates at frame boundaries, dead time per slot, leading-zero blanking.
module seg_display_scanner #(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned REFRESH_DIV  = 50000,
    parameter int unsigned BLANK_CYCLES = 500,
    localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    load,
    input  logic                    blank_lz,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    output logic [3:0]              hex_out,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    dp,
    output logic                    blank,
    output logic [IW-1:0]           digit_idx,
    output logic                    frame_done
);

    localparam int unsigned CW = $clog2(REFRESH_DIV);
    localparam int unsigned VW = 4 * NUM_DIGITS;
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(REFRESH_DIV - 1);

    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [VW-1:0]         shadow_q, shadow_d;
    logic [VW-1:0]         disp_q, disp_d;
    logic                  pending_q, pending_d;

    logic [3:0]            hex_q, hex_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic                  dp_q, dp_d;
    logic                  blank_q, blank_d;
    logic                  frame_done_q, frame_done_d;

    logic                  slot_end;
    logic                  frame_end;
    logic                  apply;

    // Scan position, shadow/display handoff.
    always_comb begin
        slot_end  = (cnt_q == LAST_CNT);
        frame_end = enable && slot_end && (idx_q == LAST_IDX);

        cnt_d = '0;
        idx_d = '0;
        if (enable) begin
            if (slot_end) begin
                cnt_d = '0;
                idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
                idx_d = idx_q;
            end
        end

        // While disabled there is no frame to tear, so a pending value lands at once.
        apply     = pending_q && (!enable || frame_end);
        disp_d    = apply ? shadow_q : disp_q;
        shadow_d  = load ? value : shadow_q;
        pending_d = load || (pending_q && !apply);
    end

    // Outputs are derived from the post-edge state so every output names the same digit.
    logic [3:0] sel_nib;
    logic       sel_dp;
    logic       sel_zero;
    logic       all_zero;
    logic       lz;
    logic       dead;

    always_comb begin
        sel_nib  = '0;
        sel_dp   = 1'b0;
        sel_zero = 1'b0;
        all_zero = 1'b1;
        for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
            all_zero = all_zero && (disp_d[4*i +: 4] == 4'h0);
            if (idx_d == IW'(i)) begin
                sel_nib  = disp_d[4*i +: 4];
                sel_dp   = dp_mask[i];
                sel_zero = all_zero;
            end
        end

        lz   = blank_lz && (idx_d != '0) && sel_zero;
        dead = (32'(cnt_d) < BLANK_CYCLES);

        an_d = '1;
        if (enable && !dead && !lz) begin
            for (int i = 0; i < int'(NUM_DIGITS); i++) begin
                if (idx_d == IW'(i)) begin
                    an_d[i] = 1'b0;
                end
            end
        end

        hex_d        = sel_nib;
        blank_d      = !enable || dead || lz;
        dp_d         = sel_dp && !blank_d;
        frame_done_d = frame_end;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            shadow_q     <= '0;
            disp_q       <= '0;
            pending_q    <= 1'b0;
            hex_q        <= '0;
            an_q         <= '1;
            dp_q         <= 1'b0;
            blank_q      <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shadow_q     <= shadow_d;
            disp_q       <= disp_d;
            pending_q    <= pending_d;
            hex_q        <= hex_d;
            an_q         <= an_d;
            dp_q         <= dp_d;
            blank_q      <= blank_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign hex_out    = hex_q;
    assign an         = an_q;
    assign dp         = dp_q;
    assign blank      = blank_q;
    assign digit_idx  = idx_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_display_scanner.sv
// Bench for seg_display_scanner: frame-position model checked every cycle plus
// directed literal checks for scan order, blanking, tear-free loads, dp, reset and enable.
module tb_seg_display_scanner;

    localparam int N = 4;
    localparam int R = 4;
    localparam int B = 1;
    localparam int F = N * R;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        load = 1'b0;
    logic        blank_lz = 1'b0;
    logic [15:0] value = 16'h0;
    logic [3:0]  dp_mask = 4'h0;

    logic [3:0]  hex_out;
    logic [3:0]  an;
    logic        dp;
    logic        blank;
    logic [1:0]  digit_idx;
    logic        frame_done;

    always #5 clk = ~clk;

    seg_display_scanner #(
        .NUM_DIGITS  (N),
        .REFRESH_DIV (R),
        .BLANK_CYCLES(B)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .value     (value),
        .load      (load),
        .blank_lz  (blank_lz),
        .dp_mask   (dp_mask),
        .hex_out   (hex_out),
        .an        (an),
        .dp        (dp),
        .blank     (blank),
        .digit_idx (digit_idx),
        .frame_done(frame_done)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Model: position within the frame (0..F-1) plus displayed/shadow values.
    int          pos = 0;
    logic [15:0] m_disp = 16'h0;
    logic [15:0] m_shadow = 16'h0;
    bit          m_pend = 1'b0;
    logic [3:0]  exp_hex = 4'h0;
    logic [3:0]  exp_an = 4'hF;
    logic        exp_dp = 1'b0;
    logic        exp_blank = 1'b1;
    logic [1:0]  exp_idx = 2'd0;
    logic        exp_fd = 1'b0;

    initial begin : model
        bit boundary;
        bit lz;
        bit dead;
        int d;
        int c;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                pos = 0; m_disp = 16'h0; m_shadow = 16'h0; m_pend = 1'b0;
                exp_hex = 4'h0; exp_an = 4'hF; exp_dp = 1'b0;
                exp_blank = 1'b1; exp_idx = 2'd0; exp_fd = 1'b0;
            end else begin
                boundary = enable && (pos == F - 1);
                pos = enable ? (pos + 1) % F : 0;
                if (m_pend && (boundary || !enable)) begin
                    m_disp = m_shadow;
                    m_pend = 1'b0;
                end
                if (load) begin
                    m_shadow = value;
                    m_pend = 1'b1;
                end
                d = pos / R;
                c = pos % R;
                lz = blank_lz && (d != 0) && ((m_disp >> (4 * d)) == 16'h0);
                dead = (c < B);
                exp_idx = 2'(d);
                exp_hex = 4'((m_disp >> (4 * d)) & 16'hF);
                exp_an = (enable && !dead && !lz) ? ~(4'b0001 << d) : 4'hF;
                exp_blank = !enable || dead || lz;
                exp_dp = enable && dp_mask[d] && !exp_blank;
                exp_fd = boundary;
            end
        end
    end

    initial begin : compare
        forever begin
            @(negedge clk);
            check("cmp_hex", 32'(hex_out), 32'(exp_hex));
            check("cmp_an", 32'(an), 32'(exp_an));
            check("cmp_dp", 32'(dp), 32'(exp_dp));
            check("cmp_blank", 32'(blank), 32'(exp_blank));
            check("cmp_idx", 32'(digit_idx), 32'(exp_idx));
            check("cmp_frame_done", 32'(frame_done), 32'(exp_fd));
        end
    end

    bit watch = 1'b0;
    int abcd_seen = 0;
    initial begin : abcd_watch
        forever begin
            @(negedge clk);
            if (watch && hex_out >= 4'hA && hex_out <= 4'hD) abcd_seen++;
        end
    end

    // Advance at least one cycle, stop at the negedge where the frame position equals p.
    task automatic goto(input int p);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (pos != p && n < 64);
        checks++;
        if (pos != p) begin
            failures++;
            $display("FAIL goto: got pos %0d expected %0d", pos, p);
        end
    endtask

    task automatic do_load(input logic [15:0] v);
        value = v;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    int fd_count;

    initial begin : stim
        repeat (2) @(negedge clk);
        check("rst_an", 32'(an), 32'hF);
        check("rst_blank", 32'(blank), 32'h1);
        check("rst_hex", 32'(hex_out), 32'h0);
        check("rst_idx", 32'(digit_idx), 32'h0);
        check("rst_fd", 32'(frame_done), 32'h0);
        rst_n = 1'b1;

        // Basic scan
        enable = 1'b1;
        do_load(16'h1234);
        goto(0);
        check("t1_fd", 32'(frame_done), 32'h1);
        check("t1_dead_an", 32'(an), 32'hF);
        goto(1);
        check("t1_d0_hex", 32'(hex_out), 32'h4);
        check("t1_d0_an", 32'(an), 32'hE);
        goto(5);
        check("t1_d1_hex", 32'(hex_out), 32'h3);
        check("t1_d1_an", 32'(an), 32'hD);
        goto(15);
        check("t1_d3_hex", 32'(hex_out), 32'h1);
        check("t1_d3_an", 32'(an), 32'h7);
        fd_count = 0;
        repeat (32) begin
            @(negedge clk);
            if (frame_done) fd_count++;
        end
        check("t1_fd_count", 32'(fd_count), 32'd2);

        // Leading-zero blanking
        blank_lz = 1'b1;
        goto(2);
        do_load(16'h0042);
        goto(0);
        goto(1);
        check("t2_d0_hex", 32'(hex_out), 32'h2);
        goto(5);
        check("t2_d1_hex", 32'(hex_out), 32'h4);
        check("t2_d1_an", 32'(an), 32'hD);
        goto(9);
        check("t2_d2_an", 32'(an), 32'hF);
        check("t2_d2_blank", 32'(blank), 32'h1);
        goto(13);
        check("t2_d3_an", 32'(an), 32'hF);
        check("t2_d3_blank", 32'(blank), 32'h1);
        blank_lz = 1'b0;
        goto(9);
        check("t2_nolz_hex", 32'(hex_out), 32'h0);
        check("t2_nolz_an", 32'(an), 32'hB);
        check("t2_nolz_blank", 32'(blank), 32'h0);
        blank_lz = 1'b1;
        do_load(16'h0000);
        goto(0);
        goto(1);
        check("t2_zero_d0_an", 32'(an), 32'hE);
        check("t2_zero_d0_hex", 32'(hex_out), 32'h0);
        goto(5);
        check("t2_zero_d1_an", 32'(an), 32'hF);

        // Tear-free update
        blank_lz = 1'b0;
        do_load(16'h1234);
        goto(0);
        watch = 1'b1;
        goto(5);
        do_load(16'hABCD);
        goto(9);
        do_load(16'h5678);
        check("t3_d2_hex", 32'(hex_out), 32'h2);
        goto(13);
        check("t3_d3_hex", 32'(hex_out), 32'h1);
        goto(1);
        check("t3_new_d0", 32'(hex_out), 32'h8);
        goto(5);
        check("t3_new_d1", 32'(hex_out), 32'h7);
        goto(9);
        check("t3_new_d2", 32'(hex_out), 32'h6);
        goto(13);
        check("t3_new_d3", 32'(hex_out), 32'h5);
        watch = 1'b0;
        check("t3_abcd_seen", 32'(abcd_seen), 32'd0);

        // Load coincident with boundary
        goto(2);
        do_load(16'h1111);
        goto(15);
        do_load(16'h2222);
        check("t4_fd", 32'(frame_done), 32'h1);
        goto(1);
        check("t4_f1_d0", 32'(hex_out), 32'h1);
        goto(13);
        check("t4_f1_d3", 32'(hex_out), 32'h1);
        goto(1);
        check("t4_f2_d0", 32'(hex_out), 32'h2);
        goto(9);
        check("t4_f2_d2", 32'(hex_out), 32'h2);

        // Decimal point
        dp_mask = 4'b0100;
        goto(8);
        check("t5_dp_dead", 32'(dp), 32'h0);
        goto(9);
        check("t5_dp_on", 32'(dp), 32'h1);
        goto(12);
        check("t5_dp_d3", 32'(dp), 32'h0);
        goto(5);
        check("t5_dp_d1", 32'(dp), 32'h0);
        dp_mask = 4'h0;

        // Asynchronous reset mid-slot with a pending load
        do_load(16'h3333);
        check("t6_pre_an", 32'(an), 32'hD);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_an", 32'(an), 32'hF);
        check("t6_async_blank", 32'(blank), 32'h1);
        check("t6_async_hex", 32'(hex_out), 32'h0);
        check("t6_async_idx", 32'(digit_idx), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        goto(0);
        goto(5);
        check("t6_discard_hex", 32'(hex_out), 32'h0);
        check("t6_discard_an", 32'(an), 32'hD);

        // Enable drop, load while disabled, re-enable
        do_load(16'h1234);
        goto(0);
        goto(6);
        enable = 1'b0;
        @(negedge clk);
        check("t6_dis_an", 32'(an), 32'hF);
        check("t6_dis_blank", 32'(blank), 32'h1);
        check("t6_dis_idx", 32'(digit_idx), 32'h0);
        check("t6_dis_hex", 32'(hex_out), 32'h4);
        do_load(16'h9876);
        @(negedge clk);
        check("t6_dis_load_hex", 32'(hex_out), 32'h6);
        enable = 1'b1;
        @(negedge clk);
        check("t6_reen_idx", 32'(digit_idx), 32'h0);
        check("t6_reen_an", 32'(an), 32'hE);
        check("t6_reen_hex", 32'(hex_out), 32'h6);
        goto(5);
        check("t6_reen_d1", 32'(hex_out), 32'h7);
        goto(0);
        check("t6_reen_fd", 32'(frame_done), 32'h1);

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
